// File: rtl/inst_loader.sv
`timescale 1ns/1ps
// Byte-stream program loader: assembles little-endian words into instruction memory while holding the CPU.
// Define INST_LOADER_CHECKSUM_EN to accept and verify a trailing XOR checksum byte after the data.
module inst_loader #(
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 32,
   parameter int INST_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  imem_write_enable,
   output logic [ADDR_WIDTH-1:0] imem_write_addr,
   output logic [INST_WIDTH-1:0] imem_write_data,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error
);

   localparam int BYTES  = INST_WIDTH / 8;
   localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_WRITE,
`ifdef INST_LOADER_CHECKSUM_EN
      S_CHECK,
`endif
      S_DONE
   } state_e;

   // Where the load goes once the last word is written (or straight after a zero length).
`ifdef INST_LOADER_CHECKSUM_EN
   localparam state_e S_TAIL = S_CHECK;
`else
   localparam state_e S_TAIL = S_DONE;
`endif

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        remaining_q, remaining_d;
   logic [ADDR_WIDTH-1:0]   word_addr_q, word_addr_d;
   logic [BIDX_W-1:0]       byte_idx_q, byte_idx_d;
   logic [INST_WIDTH-1:0]   word_q, word_d;
   logic                    in_ready_q, in_ready_d;
   logic                    write_en_q, write_en_d;
   logic [ADDR_WIDTH-1:0]   write_addr_q, write_addr_d;
   logic [INST_WIDTH-1:0]   write_data_q, write_data_d;
   logic                    cpu_hold_q, cpu_hold_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;
`ifdef INST_LOADER_CHECKSUM_EN
   logic [7:0]              csum_q, csum_d;
`endif

   logic handshake;
   assign handshake = in_valid & in_ready_q;

   always_comb begin
      // NOTE: every _d starts from its _q value, so no branch can leave a signal unassigned and infer a latch.
      state_d      = state_q;
      remaining_d  = remaining_q;
      word_addr_d  = word_addr_q;
      byte_idx_d   = byte_idx_q;
      word_d       = word_q;
      error_d      = error_q;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_d       = csum_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LEN;
               error_d = 1'b0;
            end
         end
         S_LEN: begin
            if (handshake) begin
               word_addr_d = '0;
               byte_idx_d  = '0;
`ifdef INST_LOADER_CHECKSUM_EN
               csum_d      = '0;
`endif
               if (in_data == 8'd0) begin
                  state_d = S_TAIL;
               end else begin
                  // Clamp oversize loads so the word address never wraps onto earlier words.
                  remaining_d = (int'(in_data) > DEPTH) ? CNT_W'(DEPTH) : CNT_W'(in_data);
                  state_d     = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (handshake) begin
               word_d[8*byte_idx_q +: 8] = in_data;
`ifdef INST_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ in_data;
`endif
               if (byte_idx_q == LAST_BYTE) begin
                  byte_idx_d = '0;
                  state_d    = S_WRITE;
               end else begin
                  byte_idx_d = byte_idx_q + BIDX_W'(1);
               end
            end
         end
         S_WRITE: begin
            word_addr_d = word_addr_q + ADDR_WIDTH'(1);
            remaining_d = remaining_q - CNT_W'(1);
            state_d     = (remaining_q == CNT_W'(1)) ? S_TAIL : S_DATA;
         end
`ifdef INST_LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (handshake) begin
               if (in_data != csum_q) begin
                  error_d = 1'b1;
               end
               state_d = S_DONE;
            end
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they are registered yet aligned with it.
      in_ready_d = (state_d == S_LEN) || (state_d == S_DATA);
`ifdef INST_LOADER_CHECKSUM_EN
      in_ready_d = in_ready_d || (state_d == S_CHECK);
`endif
      write_en_d   = (state_d == S_WRITE);
      write_addr_d = write_addr_q;
      write_data_d = write_data_q;
      if (state_d == S_WRITE) begin
         write_addr_d = word_addr_q;
         write_data_d = word_d;
      end
      cpu_hold_d = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments only, so every flop samples pre-edge values regardless of ordering.
      if (rst) begin
         state_q      <= S_IDLE;
         remaining_q  <= '0;
         word_addr_q  <= '0;
         byte_idx_q   <= '0;
         word_q       <= '0;
         in_ready_q   <= 1'b0;
         write_en_q   <= 1'b0;
         write_addr_q <= '0;
         write_data_q <= '0;
         cpu_hold_q   <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
         csum_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         word_addr_q  <= word_addr_d;
         byte_idx_q   <= byte_idx_d;
         word_q       <= word_d;
         in_ready_q   <= in_ready_d;
         write_en_q   <= write_en_d;
         write_addr_q <= write_addr_d;
         write_data_q <= write_data_d;
         cpu_hold_q   <= cpu_hold_d;
         done_q       <= done_d;
         error_q      <= error_d;
`ifdef INST_LOADER_CHECKSUM_EN
         csum_q       <= csum_d;
`endif
      end
   end

   assign in_ready          = in_ready_q;
   assign imem_write_enable = write_en_q;
   assign imem_write_addr   = write_addr_q;
   assign imem_write_data   = write_data_q;
   assign cpu_hold          = cpu_hold_q;
   assign done              = done_q;
   assign error             = error_q;

endmodule

// File: tb/tb_inst_loader.sv
`timescale 1ns/1ps
// Randomized bench for inst_loader: each load is predicted from the byte stream by a small model.
// Follows INST_LOADER_CHECKSUM_EN the same way the design does.
module tb_inst_loader;

   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam int IW    = 32;
`ifdef INST_LOADER_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic          imem_write_enable;
   logic [AW-1:0] imem_write_addr;
   logic [IW-1:0] imem_write_data;
   logic          cpu_hold;
   logic          done;
   logic          error;

   always #5 clk = ~clk;

   inst_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .INST_WIDTH(IW)) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .in_data           (in_data),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .imem_write_enable (imem_write_enable),
      .imem_write_addr   (imem_write_addr),
      .imem_write_data   (imem_write_data),
      .cpu_hold          (cpu_hold),
      .done              (done),
      .error             (error)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Passive monitor: never cleared, loads work on differences from a snapshot.
   int            cyc = 0;
   int            hs_cyc[$];
   int            wr_cyc[$];
   logic [AW-1:0] wr_addr[$];
   logic [IW-1:0] wr_data[$];
   int            cons_cnt = 0;
   int            done_cnt = 0;
   int            done_cyc = 0;
   logic          done_err = 1'b0;
   logic          done_hold = 1'b0;
   int            ready_in_write = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (in_valid && in_ready) begin
         hs_cyc.push_back(cyc);
         cons_cnt <= cons_cnt + 1;
      end
      if (imem_write_enable) begin
         wr_cyc.push_back(cyc);
         wr_addr.push_back(imem_write_addr);
         wr_data.push_back(imem_write_data);
         if (in_ready) ready_in_write <= ready_in_write + 1;
      end
      if (done) begin
         done_cnt  <= done_cnt + 1;
         done_cyc  <= cyc;
         done_err  <= error;
         done_hold <= cpu_hold;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the byte was taken.
   task automatic send_byte(input logic [7:0] b, output bit ok);
      in_data  = b;
      in_valid = 1'b1;
      ok       = 1'b0;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   function automatic logic [7:0] xor_data(input logic [7:0] s[$], input int nbytes);
      logic [7:0] x = 8'h00;
      for (int i = 1; i <= nbytes; i++) x ^= s[i];
      return x;
   endfunction

   task automatic do_load(input string name, input logic [7:0] s[$],
                          input int gap_lo, input int gap_hi, input bit poke_start);
      int            n, ncons, hb, wb, cb, db, gap, exp_done;
      logic [IW-1:0] exp_w[$];
      bit            exp_err, ok;

      // Model: clamp the count, pack bytes little-endian, trailer compared to XOR of the data.
      n = (int'(s[0]) > DEPTH) ? DEPTH : int'(s[0]);
      for (int j = 0; j < n; j++)
         exp_w.push_back({s[4*j+4], s[4*j+3], s[4*j+2], s[4*j+1]});
      ncons   = 1 + 4*n + (CK ? 1 : 0);
      exp_err = CK && (s[1+4*n] != xor_data(s, 4*n));

      hb = hs_cyc.size();
      wb = wr_addr.size();
      cb = cons_cnt;
      db = done_cnt;

      pulse_start();
      check({name, ":hold_after_start"}, cpu_hold, 1);
      check({name, ":error_cleared"}, error, 0);
      check({name, ":ready_in_len"}, in_ready, 1);

      for (int k = 0; k < ncons; k++) begin
         send_byte(s[k], ok);
         if (!ok) begin
            check({name, ":byte_timeout"}, 0, 1);
            break;
         end
         gap = $urandom_range(gap_hi, gap_lo);
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
         if (poke_start && k == 2) pulse_start();
      end

      // Offer the next unconsumed byte; the loader must leave it alone.
      if (s.size() > ncons) begin
         in_data  = s[ncons];
         in_valid = 1'b1;
      end
      for (int t = 0; t < 20; t++) begin
         if (done_cnt != db) break;
         @(posedge clk);
         #1;
      end
      check({name, ":done_seen"}, done_cnt - db, 1);
      @(posedge clk);
      #1;
      check({name, ":hold_released"}, cpu_hold, 0);
      check({name, ":done_one_cycle"}, done, 0);
      check({name, ":error_sticky"}, error, exp_err);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;

      check({name, ":bytes_consumed"}, cons_cnt - cb, ncons);
      check({name, ":done_count"}, done_cnt - db, 1);
      check({name, ":write_count"}, wr_addr.size() - wb, n);
      check({name, ":error_at_done"}, done_err, exp_err);
      check({name, ":hold_at_done"}, done_hold, 1);
      check({name, ":no_ready_in_write"}, ready_in_write, 0);
      for (int j = 0; j < n && wb + j < wr_addr.size(); j++) begin
         check($sformatf("%s:addr[%0d]", name, j), wr_addr[wb+j], j);
         check($sformatf("%s:data[%0d]", name, j), wr_data[wb+j], exp_w[j]);
         if (hb + 4*j + 4 < hs_cyc.size())
            check($sformatf("%s:wr_lat[%0d]", name, j), wr_cyc[wb+j], hs_cyc[hb+4*j+4] + 1);
      end
      if (hs_cyc.size() == hb + ncons) begin
         exp_done = hs_cyc[hb+ncons-1] + ((n == 0 || CK) ? 1 : 2);
         check({name, ":done_latency"}, done_cyc, exp_done);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] s[$];
      logic [7:0] x;
      int         len, wb, db;
      bit         ok;

      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #12;
      check("reset_outputs", {in_ready, imem_write_enable, imem_write_addr, imem_write_data,
                              cpu_hold, done, error}, 0);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      s = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h20, 8'h00, 8'h80};
      do_load("two_word", s, 0, 0, 1'b0);
      s[9] = 8'h00;
      do_load("two_word_bad_trailer", s, 0, 0, 1'b0);
      s[9] = 8'hA0;
      do_load("backpressure", s, 3, 3, 1'b1);
      s = '{8'h00, 8'h00};
      do_load("empty", s, 0, 0, 1'b0);

      s.delete();
      s.push_back(8'h28);
      repeat (160) s.push_back(8'($urandom));
      do_load("clamp", s, 0, 1, 1'b0);

      for (int r = 0; r < 6; r++) begin
         s.delete();
         len = $urandom_range(40, 0);
         s.push_back(8'(len));
         repeat (4*len + 1) s.push_back(8'($urandom));
         x = xor_data(s, 4*((len > DEPTH) ? DEPTH : len));
         if ($urandom_range(1, 0) == 1) s[1 + 4*((len > DEPTH) ? DEPTH : len)] = x;
         do_load($sformatf("random%0d", r), s, 0, 2, 1'b0);
      end

      // Asynchronous reset in the middle of a word.
      wb = wr_addr.size();
      db = done_cnt;
      pulse_start();
      send_byte(8'h05, ok);
      send_byte(8'hAA, ok);
      send_byte(8'hBB, ok);
      check("abort:hold_before", cpu_hold, 1);
      #2 rst = 1'b1;
      #1;
      check("abort:async_outputs", {in_ready, imem_write_enable, imem_write_addr, imem_write_data,
                                    cpu_hold, done, error}, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      check("abort:no_write", wr_addr.size() - wb, 0);
      check("abort:no_done", done_cnt - db, 0);
      check("abort:hold_low", cpu_hold, 0);

      s = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h20, 8'h00, 8'h80};
      do_load("after_abort", s, 0, 1, 1'b0);

      // Reset dominates a simultaneous start.
      rst   = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      check("rst_start:hold", cpu_hold, 0);
      @(posedge clk);
      #1;
      check("rst_start:idle", {cpu_hold, in_ready}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
